// File: rtl/imem_loader.sv
// Instruction memory loader: takes a length-prefixed little-endian byte stream
// and writes it word by word into instruction memory, holding the core while loading.
module imem_loader #(
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ADDR_STRIDE = 32'd4,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t      state_r;
    logic [15:0] len_r;
    logic [31:0] word_r;
    logic [1:0]  byte_idx_r;
    logic [31:0] next_addr_r;
    logic [31:0] idle_r;

    logic        accept_s;
    logic [15:0] len_s;
    logic        len_bad_s;
    logic        timeout_s;
    logic [15:0] words_next_s;

    assign accept_s     = byte_valid && byte_ready;
    assign len_s        = {byte_in, len_r[7:0]};
    assign len_bad_s    = (len_s == 16'd0) || (32'(len_s) > DEPTH);
    // Fires on the idle cycle that brings the counter up to TIMEOUT.
    assign timeout_s    = (TIMEOUT != 32'd0) && !accept_s && (idle_r == (TIMEOUT - 32'd1));
    assign words_next_s = words_loaded + 16'd1;

    // Load sequencer: state, assembly registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            len_r        <= 16'd0;
            word_r       <= 32'd0;
            byte_idx_r   <= 2'd0;
            next_addr_r  <= BASE_ADDR;
            idle_r       <= 32'd0;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 32'd0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_r      <= LEN_LO;
                        byte_ready   <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 16'd0;
                        idle_r       <= 32'd0;
                        byte_idx_r   <= 2'd0;
                        next_addr_r  <= BASE_ADDR;
                    end
                end
                LEN_LO: begin
                    if (accept_s) begin
                        len_r[7:0] <= byte_in;
                        idle_r     <= 32'd0;
                        state_r    <= LEN_HI;
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        error      <= 1'b1;
                        cpu_hold   <= 1'b0;
                        byte_ready <= 1'b0;
                    end else begin
                        idle_r <= idle_r + 32'd1;
                    end
                end
                LEN_HI: begin
                    if (accept_s) begin
                        len_r[15:8] <= byte_in;
                        idle_r      <= 32'd0;
                        if (len_bad_s) begin
                            state_r    <= ERR;
                            error      <= 1'b1;
                            cpu_hold   <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state_r    <= DATA;
                            byte_idx_r <= 2'd0;
                        end
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        error      <= 1'b1;
                        cpu_hold   <= 1'b0;
                        byte_ready <= 1'b0;
                    end else begin
                        idle_r <= idle_r + 32'd1;
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        word_r[{byte_idx_r, 3'b000} +: 8] <= byte_in;
                        byte_idx_r <= byte_idx_r + 2'd1;
                        idle_r     <= 32'd0;
                        if (byte_idx_r == 2'd3) begin
                            state_r    <= WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_addr   <= next_addr_r;
                            mem_wdata  <= {byte_in, word_r[23:0]};
                        end
                    end else if (timeout_s) begin
                        // The partially assembled word is simply abandoned.
                        state_r    <= ERR;
                        error      <= 1'b1;
                        cpu_hold   <= 1'b0;
                        byte_ready <= 1'b0;
                    end else begin
                        idle_r <= idle_r + 32'd1;
                    end
                end
                WRITE: begin
                    mem_we       <= 1'b0;
                    words_loaded <= words_next_s;
                    next_addr_r  <= next_addr_r + ADDR_STRIDE;
                    idle_r       <= 32'd0;
                    if (words_next_s == len_r) begin
                        state_r  <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state_r    <= DATA;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

endmodule
